// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single ram_ctrl port among camera (0), VGA (1) and UART (2) requesters.
// Runs one transaction at a time with a timeout. Define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [59:0] i_addr,
  input  logic [95:0] i_wdata,
  output logic [2:0]  o_gnt,
  output logic [2:0]  o_done,
  output logic [31:0] o_rdata,
  output logic        o_timeout,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [19:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_workdone,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  // Counter value seen in the last BUSY cycle before the abort edge.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [1:0]  r_owner, w_owner_d;
  logic [2:0]  r_gnt, w_gnt_d;
  logic [2:0]  r_done, w_done_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        r_timeout, w_timeout_d;
  logic        r_mem_read, w_mem_read_d;
  logic        r_mem_write, w_mem_write_d;
  logic [19:0] r_mem_addr, w_mem_addr_d;
  logic [31:0] r_mem_wdata, w_mem_wdata_d;

  logic        w_any;
  logic [1:0]  w_win;
  logic        w_sel_we;
  logic [19:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_fin;

`ifdef SRAM_ARB_RR_EN
  logic [1:0] r_last, w_last_d;
  logic [1:0] w_c0, w_c1, w_c2;

  // Search order starts at the port after the last grant, wrapping 2 -> 0.
  always_comb begin
    w_c0  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_c1  = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_any = |i_req;
    if (i_req[w_c0])      w_win = w_c0;
    else if (i_req[w_c1]) w_win = w_c1;
    else                  w_win = w_c2;
  end
`else
  always_comb begin
    w_any = |i_req;
    if (i_req[1])      w_win = 2'd1;
    else if (i_req[0]) w_win = 2'd0;
    else               w_win = 2'd2;
  end
`endif

  always_comb begin
    case (w_win)
      2'd1: begin
        w_sel_we    = i_we[1];
        w_sel_addr  = i_addr[39:20];
        w_sel_wdata = i_wdata[63:32];
      end
      2'd2: begin
        w_sel_we    = i_we[2];
        w_sel_addr  = i_addr[59:40];
        w_sel_wdata = i_wdata[95:64];
      end
      default: begin
        w_sel_we    = i_we[0];
        w_sel_addr  = i_addr[19:0];
        w_sel_wdata = i_wdata[31:0];
      end
    endcase
  end

  // workdone and timeout share the same completion path; workdone takes precedence below.
  assign w_fin = (r_state == StBusy) && (i_mem_workdone || (r_cnt == CntLast));

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_any) w_state_d = StBusy;
      StBusy:    if (w_fin) w_state_d = StRelease;
      StRelease: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d       = r_cnt;
    w_owner_d     = r_owner;
    w_gnt_d       = r_gnt;
    w_done_d      = 3'b000;
    w_rdata_d     = r_rdata;
    w_timeout_d   = r_timeout;
    w_mem_read_d  = r_mem_read;
    w_mem_write_d = r_mem_write;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
`ifdef SRAM_ARB_RR_EN
    w_last_d      = r_last;
`endif
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_d       = 3'b001 << w_win;
          w_owner_d     = w_win;
          w_mem_read_d  = ~w_sel_we;
          w_mem_write_d = w_sel_we;
          w_mem_addr_d  = w_sel_addr;
          w_mem_wdata_d = w_sel_wdata;
          w_cnt_d       = 8'd0;
`ifdef SRAM_ARB_RR_EN
          w_last_d      = w_win;
`endif
        end
      end
      StBusy: begin
        w_cnt_d = r_cnt + 8'd1;
        if (w_fin) begin
          w_gnt_d       = 3'b000;
          w_mem_read_d  = 1'b0;
          w_mem_write_d = 1'b0;
          w_done_d      = 3'b001 << r_owner;
          if (i_mem_workdone) begin
            if (r_mem_read) w_rdata_d = i_mem_rdata;
          end else begin
            w_timeout_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt       <= 8'd0;
      r_owner     <= 2'd0;
      r_gnt       <= 3'b000;
      r_done      <= 3'b000;
      r_rdata     <= 32'd0;
      r_timeout   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 20'd0;
      r_mem_wdata <= 32'd0;
`ifdef SRAM_ARB_RR_EN
      r_last      <= 2'd2;
`endif
    end else begin
      r_cnt       <= w_cnt_d;
      r_owner     <= w_owner_d;
      r_gnt       <= w_gnt_d;
      r_done      <= w_done_d;
      r_rdata     <= w_rdata_d;
      r_timeout   <= w_timeout_d;
      r_mem_read  <= w_mem_read_d;
      r_mem_write <= w_mem_write_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
`ifdef SRAM_ARB_RR_EN
      r_last      <= w_last_d;
`endif
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_timeout   = r_timeout;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed plus randomized transactions against a transaction-level model
// of the arbiter (winner choice, latency, rdata and sticky timeout).
module tb_sram_arbiter;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [59:0] addr;
  logic [95:0] wdata;
  logic [2:0]  gnt, done;
  logic [31:0] rdata, mwdata, mem_rdata;
  logic        tmo, mrd, mwr, workdone;
  logic [19:0] maddr;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_we           (we),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_gnt          (gnt),
    .o_done         (done),
    .o_rdata        (rdata),
    .o_timeout      (tmo),
    .o_mem_read     (mrd),
    .o_mem_write    (mwr),
    .o_mem_addr     (maddr),
    .o_mem_wdata    (mwdata),
    .i_mem_workdone (workdone),
    .i_mem_rdata    (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_last    = 2;
  logic [31:0] m_rdata   = 32'd0;
  logic        m_timeout = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef SRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`else
    int order [3] = '{1, 0, 2};
    for (int k = 0; k < 3; k++) if (r[order[k]]) return order[k];
`endif
    return -1;
  endfunction

  task automatic set_port(input int p, input logic w, input logic [19:0] a, input logic [31:0] d);
    we[p]            = w;
    addr[p*20 +: 20] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_timeout"}, tmo, 0);
    check({tag, "_strobes"}, {mwr, mrd}, 0);
    check({tag, "_mem_addr"}, maddr, 0);
    check({tag, "_mem_wdata"}, mwdata, 0);
  endtask

  // Called in an IDLE cycle with req already driven; returns in the following IDLE cycle.
  task automatic txn(input int lat, input logic [31:0] rd, input bit keep, input bit drop_mid);
    int p, e;
    logic [19:0] a;
    logic [31:0] d;
    logic w;
    p = pick(req, m_last);
    if (p < 0) return;
    a = addr[p*20 +: 20];
    d = wdata[p*32 +: 32];
    w = we[p];
    m_last = p;
    tick();
    check("grant", gnt, 32'd1 << p);
    check("grant_read", mrd, !w);
    check("grant_write", mwr, w);
    check("grant_addr", maddr, a);
    check("grant_wdata", mwdata, d);
    check("grant_done", done, 0);
    e = (lat < int'(T)) ? lat : int'(T);
    for (int k = 1; k <= e; k++) begin
      workdone  = (k == lat);
      mem_rdata = (k == lat) ? rd : $urandom;
      if (drop_mid && k == 2) req[p] = 1'b0;
      tick();
      if (k < e) begin
        check("hold_gnt", gnt, 32'd1 << p);
        check("hold_strobes", {mwr, mrd}, {w, !w});
        check("hold_addr", maddr, a);
        check("hold_wdata", mwdata, d);
        check("hold_done", done, 0);
      end
    end
    workdone = 1'b0;
    if (lat <= int'(T) && !w) m_rdata = rd;
    if (lat > int'(T)) m_timeout = 1'b1;
    check("done_pulse", done, 32'd1 << p);
    check("done_gnt", gnt, 0);
    check("done_strobes", {mwr, mrd}, 0);
    check("done_rdata", rdata, m_rdata);
    check("done_timeout", tmo, m_timeout);
    if (!keep) req[p] = 1'b0;
    tick();
    check("release_done", done, 0);
    check("release_gnt", gnt, 0);
    check("release_strobes", {mwr, mrd}, 0);
  endtask

  initial begin
    rst = 1'b0; req = 3'b000; we = 3'b000; addr = '0; wdata = '0;
    workdone = 1'b0; mem_rdata = 32'd0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;

    // workdone outside BUSY must be ignored
    workdone = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check("idle_wd_done", done, 0);
    check("idle_wd_gnt", gnt, 0);
    check("idle_wd_rdata", rdata, 0);
    workdone = 1'b0;

    // Contention: all three request at once, each drops after its done
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 20'(p * 16 + 5), $urandom);
    req = 3'b111;
    txn(2, 32'hA000_0001, 1'b0, 1'b0);
    txn(2, 32'hA000_0002, 1'b0, 1'b0);
    txn(2, 32'hA000_0003, 1'b0, 1'b0);
    req = 3'b111;
    txn(2, 32'hA000_0004, 1'b0, 1'b0);
    req = 3'b000;
    tick();
    req = 3'b000;

    // Single read
    set_port(2, 1'b0, 20'h00010, 32'h0);
    req = 3'b100;
    txn(3, 32'hDEADBEEF, 1'b0, 1'b0);
    check("single_read_rdata", rdata, 32'hDEADBEEF);

    // Write path
    set_port(0, 1'b1, 20'hABCDE, 32'h12345678);
    req = 3'b001;
    txn(4, 32'h5555_AAAA, 1'b0, 1'b0);
    check("write_rdata_kept", rdata, 32'hDEADBEEF);

    // workdone coincides with timeout
    set_port(1, 1'b0, 20'h11111, 32'h0);
    req = 3'b010;
    txn(int'(T), 32'hC0C0_C0C0, 1'b0, 1'b0);
    check("coincide_no_timeout", tmo, 0);

    // Port drops req mid-BUSY
    set_port(2, 1'b0, 20'h22222, 32'h0);
    req = 3'b100;
    txn(5, 32'h0BAD_F00D, 1'b0, 1'b1);

    // Timeout, then a normal request
    set_port(1, 1'b0, 20'h33333, 32'h0);
    req = 3'b010;
    txn(1000, 32'hFFFF_0000, 1'b0, 1'b0);
    check("timeout_sticky", tmo, 1);
    set_port(0, 1'b0, 20'h44444, 32'h0);
    req = 3'b001;
    txn(2, 32'h1357_9BDF, 1'b0, 1'b0);
    check("after_timeout_rdata", rdata, 32'h1357_9BDF);
    check("after_timeout_flag", tmo, 1);

    // Reset mid-BUSY
    set_port(0, 1'b1, 20'h55555, 32'h7777_7777);
    req = 3'b001;
    tick();
    check("pre_reset_gnt", gnt, 3'b001);
    tick();
    rst = 1'b0;
    tick();
    check_reset_vals("busy_reset");
    m_last = 2; m_rdata = 32'd0; m_timeout = 1'b0;
    rst = 1'b1;
    txn(2, 32'h2468_ACE0, 1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 3; p++) begin
        if (!req[p] && $urandom_range(1, 0) == 1) begin
          set_port(p, 1'($urandom_range(1, 0)), 20'($urandom), $urandom);
          req[p] = 1'b1;
        end
      end
      if (req == 3'b000) begin
        set_port(0, 1'($urandom_range(1, 0)), 20'($urandom), $urandom);
        req[0] = 1'b1;
      end
      txn(int'($urandom_range(12, 1)), $urandom, 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
